datapath_exec_unit: RTL and testbench
=====================================

# datapath_exec_unit

Execution datapath controlled by the control-word FSMs (shift-add multiplier and future sequencers). Holds a 16×16 register file, an ALU and a registered flags word. Every cycle it executes the control word presented on its inputs and returns `Flags`, which the FSM uses for its branch decisions. It is the responder side of the FSM control interface.

## Interface
- `BIT_WIDTH`, 16: data and register width.
- `OPCODE_WIDTH`, 8: opcode width.
- `FLAG_WIDTH`, 5: flags width.
- `SEL_WIDTH`, 4: register select width; the register count is 2^SEL_WIDTH.
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Rst`  in  1  reset, asynchronous, active-low.
- `Rsrc_mux_sel`  in  SEL_WIDTH  source register index.
- `Rdest_mux_sel`  in  SEL_WIDTH  destination register index, which is also operand A.
- `Imm_mux_sel`  in  1  operand B select: 1 selects `Imm_val`, 0 selects R[Rsrc].
- `Imm_val`  in  BIT_WIDTH  immediate operand.
- `Opcode`  in  OPCODE_WIDTH  operation.
- `Reg_File_En`  in  BIT_WIDTH  per-register write enable; bit i enables a write to Ri.
- `Flags`  out  FLAG_WIDTH  registered flags: [4]=C, [3]=Z, [2]=F, [1]=L, [0]=N.
- `Result`  out  BIT_WIDTH  combinational ALU result for the current control word.

## Operation
- A = R[Rdest_mux_sel]. B = Imm_mux_sel ? Imm_val : R[Rsrc_mux_sel].
- Opcode decode (x = don't care):
  - 0000_0101 ADD, 0101_x ADDI: A+B.
  - 0000_0110 ADDU, 0110_x ADDUI: A+B.
  - 0000_0111 ADDC, 0111_x ADDCI: A+B+C.
  - 0000_1001 SUB, 1001_x SUBI: A−B.
  - 0000_1011 CMP, 1011_x CMPI: A−B, never writes a register.
  - 0000_0001/0001_x AND: A&B. 0000_0010/0010_x OR: A|B. 0000_0011/0011_x XOR: A^B.
  - 0000_0100 NOT: ~A, B ignored.
  - 1000_0100 LSH, 1000_000x LSHI: A << B[3:0].
  - 1000_0110 ARSH, 1000_001x ARSHI: arithmetic right shift by B[3:0].
  - 1000_100x RSH, 1000_101x RSHI: logical right shift by B[3:0].
  - 0000_0000 NOP.
  - Any other opcode: handled as NOP with Result = 0.
- Adds and subtracts are computed 17 bits wide; the result is truncated to 16 bits.
- Register write: at the rising edge, every Ri with Reg_File_En[i]==1 takes Result. The write is suppressed for NOP, undefined opcodes and CMP/CMPI.
- Multiple enable bits set: every enabled register receives Result (broadcast).
- Enable bits that are 0 or x never write. The bench drives 0 on unused bits.
- Flag update happens at the rising edge, for every non-NOP defined opcode:
  - Z = (Result==0). For CMP/CMPI, Z = (A==B).
  - N = Result[15]. For CMP/CMPI, N = signed A<B.
  - C = carry-out for ADD/ADDU/ADDC families; borrow (unsigned A<B) for SUB family. Held by all other ops.
  - F = signed overflow for ADD/ADDC/SUB families. Held by all other ops.
  - L = unsigned A<B for CMP/CMPI only. Held by all other ops.
- NOP and undefined opcodes hold all flags and all registers.

## Timing
- Reset (asynchronous, while Rst=0): all registers 0 and Flags = 5'b0. Result then reflects the combinational operation on the zeroed registers.
- Reset mid-sequence clears all state immediately. The first control word after Rst rises is executed normally.
- Result has zero latency: it is combinational from the inputs and the register contents.
- Register write latency is 1 edge. The new value is visible on A/B in the next cycle.
- Back-to-back dependent ops need no stall.
- Flags reflect the last executed flag-setting op and are valid in the cycle after that op.
- The FSM tests Flags in the cycle following the op, e.g. an AND in one state and a NOP in the branch state.
- Rsrc = Rdest is legal. The write uses the pre-edge operands.

## Configuration
- `DATAPATH_DEBUG_PORT_EN` defined:
  - Adds `Dbg_sel` (in, SEL_WIDTH) and `Dbg_data` (out, BIT_WIDTH).
  - Dbg_data = R[Dbg_sel], combinational, read-only.
  - Has no effect on execution.
- Not defined: those ports and their logic are absent.

## Structure
- Shared package `datapath_pkg`:
  - opcode constants and casez patterns;
  - flag bit index constants (FLAG_C=4, FLAG_Z=3, FLAG_F=2, FLAG_L=1, FLAG_N=0);
  - width parameters.
- The FSMs import the same package.
- One sub-module, `alu_core`:
  - purely combinational;
  - inputs: A, B, Opcode, C_in;
  - outputs: Result, next-flag values, flag-update mask, write-allowed.
- The top level keeps the register file, operand muxes and flags register.

## Test plan
- Reset: Rst=0 mid-run → all registers 0, Flags=0. After release, ADDUI R0,6 with En=0x0001 → R0=6.
- Multiply sequence: R0=6, R1=5, control sequence CMPI / AND / ADDU R2 / LSHI R0 / RSHI R1 until R1=0 → R2=30, final Flags[3]=1.
- Overflow: R0=0x7FFF, ADDI R0,1 → R0=0x8000, F=1, N=1, C=0, Z=0.
- Carry chain: R0=0xFFFF, ADDUI R0,1 → R0=0, C=1, Z=1. Then R1=0, ADDC R1,R1 → R1=1.
- Compare and hold: R3=3, CMPI R3,5 → L=1, N=1, Z=0, R3 unchanged. A following NOP leaves Flags and all registers unchanged.
- Broadcast and shifts: En=0x0030 with ADDUI R4,0x8001 → R4=R5=0x8001 (R4=0 before). Then ARSHI R4,1 with En=0x0010 → R4=0xC000.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared definitions for the execution datapath and the control-word FSMs that drive it.
// Latency: n/a (types, constants and a combinational opcode decoder only).
// Backpressure: n/a.
package datapath_pkg;

    // Default widths shared by the datapath and its sequencers
    localparam int DP_BIT_WIDTH    = 16;
    localparam int DP_OPCODE_WIDTH = 8;
    localparam int DP_FLAG_WIDTH   = 5;
    localparam int DP_SEL_WIDTH    = 4;

    // Bit positions inside the Flags word
    localparam int FLAG_C = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_N = 0;

    // Register-register opcodes (immediate forms carry the class in the upper nibble)
    localparam logic [7:0] OP_NOP  = 8'b0000_0000;
    localparam logic [7:0] OP_AND  = 8'b0000_0001;
    localparam logic [7:0] OP_OR   = 8'b0000_0010;
    localparam logic [7:0] OP_XOR  = 8'b0000_0011;
    localparam logic [7:0] OP_NOT  = 8'b0000_0100;
    localparam logic [7:0] OP_ADD  = 8'b0000_0101;
    localparam logic [7:0] OP_ADDU = 8'b0000_0110;
    localparam logic [7:0] OP_ADDC = 8'b0000_0111;
    localparam logic [7:0] OP_SUB  = 8'b0000_1001;
    localparam logic [7:0] OP_CMP  = 8'b0000_1011;
    localparam logic [7:0] OP_LSH  = 8'b1000_0100;
    localparam logic [7:0] OP_ARSH = 8'b1000_0110;
    localparam logic [7:0] OP_RSH  = 8'b1000_1000;

    // Representative immediate encodings (low bits are don't-care)
    localparam logic [7:0] OP_ANDI  = 8'b0001_0000;
    localparam logic [7:0] OP_ORI   = 8'b0010_0000;
    localparam logic [7:0] OP_XORI  = 8'b0011_0000;
    localparam logic [7:0] OP_ADDI  = 8'b0101_0000;
    localparam logic [7:0] OP_ADDUI = 8'b0110_0000;
    localparam logic [7:0] OP_ADDCI = 8'b0111_0000;
    localparam logic [7:0] OP_SUBI  = 8'b1001_0000;
    localparam logic [7:0] OP_CMPI  = 8'b1011_0000;
    localparam logic [7:0] OP_LSHI  = 8'b1000_0000;
    localparam logic [7:0] OP_ARSHI = 8'b1000_0010;
    localparam logic [7:0] OP_RSHI  = 8'b1000_1010;

    // Operation class after decode; register and immediate forms collapse together
    typedef enum logic [3:0] {
        OPC_NOP,
        OPC_ADD,
        OPC_ADDU,
        OPC_ADDC,
        OPC_SUB,
        OPC_CMP,
        OPC_AND,
        OPC_OR,
        OPC_XOR,
        OPC_NOT,
        OPC_LSH,
        OPC_ARSH,
        OPC_RSH,
        OPC_UNDEF
    } op_class_e;

    // Map a raw opcode onto its operation class; unlisted encodings are OPC_UNDEF
    function automatic op_class_e decode_opcode(input logic [7:0] opc);
        op_class_e cls;
        cls = OPC_UNDEF;
        casez (opc)
            8'b0000_0000:              cls = OPC_NOP;
            8'b0000_0001, 8'b0001_????: cls = OPC_AND;
            8'b0000_0010, 8'b0010_????: cls = OPC_OR;
            8'b0000_0011, 8'b0011_????: cls = OPC_XOR;
            8'b0000_0100:              cls = OPC_NOT;
            8'b0000_0101, 8'b0101_????: cls = OPC_ADD;
            8'b0000_0110, 8'b0110_????: cls = OPC_ADDU;
            8'b0000_0111, 8'b0111_????: cls = OPC_ADDC;
            8'b0000_1001, 8'b1001_????: cls = OPC_SUB;
            8'b0000_1011, 8'b1011_????: cls = OPC_CMP;
            8'b1000_0100, 8'b1000_000?: cls = OPC_LSH;
            8'b1000_0110, 8'b1000_001?: cls = OPC_ARSH;
            8'b1000_100?, 8'b1000_101?: cls = OPC_RSH;
            default:                   cls = OPC_UNDEF;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/datapath_exec_unit_alu.sv
// Combinational ALU: result, candidate flag values, flag-update mask and write permission.
// Latency: zero (purely combinational).
// Backpressure: none; evaluates whatever control word is presented.
module alu_core
    import datapath_pkg::*;
#(
    parameter int BIT_WIDTH    = DP_BIT_WIDTH,
    parameter int OPCODE_WIDTH = DP_OPCODE_WIDTH,
    parameter int FLAG_WIDTH   = DP_FLAG_WIDTH
) (
    input  logic [BIT_WIDTH-1:0]    i_a,
    input  logic [BIT_WIDTH-1:0]    i_b,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic                    i_c_in,
    output logic [BIT_WIDTH-1:0]    o_result,
    output logic [FLAG_WIDTH-1:0]   o_flag_next,
    output logic [FLAG_WIDTH-1:0]   o_flag_mask,
    output logic                    o_wr_allow
);

    localparam int MSB = BIT_WIDTH - 1;
    localparam int SHW = $clog2(BIT_WIDTH);

    op_class_e            w_cls;
    logic [BIT_WIDTH:0]   w_add_sum;
    logic [BIT_WIDTH:0]   w_sub_diff;
    logic                 w_add_ovf;
    logic                 w_sub_ovf;
    logic                 w_carry_used;
    logic [SHW-1:0]       w_shamt;
    logic [BIT_WIDTH-1:0] w_arsh;
    logic                 w_is_cmp;
    logic                 w_c;
    logic                 w_f;

    assign w_cls        = decode_opcode(i_opcode);
    // Only the ADDC family folds the stored carry into the sum
    assign w_carry_used = (w_cls == OPC_ADDC) & i_c_in;
    assign w_add_sum    = {1'b0, i_a} + {1'b0, i_b} + {{BIT_WIDTH{1'b0}}, w_carry_used};
    // Bit BIT_WIDTH of the difference is the borrow, i.e. unsigned A < B
    assign w_sub_diff   = {1'b0, i_a} - {1'b0, i_b};
    assign w_add_ovf    = (i_a[MSB] == i_b[MSB]) && (w_add_sum[MSB] != i_a[MSB]);
    assign w_sub_ovf    = (i_a[MSB] != i_b[MSB]) && (w_sub_diff[MSB] != i_a[MSB]);
    assign w_shamt      = i_b[SHW-1:0];
    assign w_arsh       = $unsigned($signed(i_a) >>> w_shamt);

    // Select the result and decide which flags this operation is allowed to touch
    always_comb begin
        o_result    = '0;
        o_flag_mask = '0;
        o_wr_allow  = 1'b0;
        w_is_cmp    = 1'b0;
        w_c         = 1'b0;
        w_f         = 1'b0;
        case (w_cls)
            OPC_ADD, OPC_ADDC: begin
                o_result            = w_add_sum[MSB:0];
                w_c                 = w_add_sum[BIT_WIDTH];
                w_f                 = w_add_ovf;
                o_flag_mask[FLAG_C] = 1'b1;
                o_flag_mask[FLAG_F] = 1'b1;
                o_wr_allow          = 1'b1;
            end
            OPC_ADDU: begin
                o_result            = w_add_sum[MSB:0];
                w_c                 = w_add_sum[BIT_WIDTH];
                o_flag_mask[FLAG_C] = 1'b1;
                o_wr_allow          = 1'b1;
            end
            OPC_SUB: begin
                o_result            = w_sub_diff[MSB:0];
                w_c                 = w_sub_diff[BIT_WIDTH];
                w_f                 = w_sub_ovf;
                o_flag_mask[FLAG_C] = 1'b1;
                o_flag_mask[FLAG_F] = 1'b1;
                o_wr_allow          = 1'b1;
            end
            OPC_CMP: begin
                o_result            = w_sub_diff[MSB:0];
                w_is_cmp            = 1'b1;
                o_flag_mask[FLAG_L] = 1'b1;
            end
            OPC_AND: begin
                o_result   = i_a & i_b;
                o_wr_allow = 1'b1;
            end
            OPC_OR: begin
                o_result   = i_a | i_b;
                o_wr_allow = 1'b1;
            end
            OPC_XOR: begin
                o_result   = i_a ^ i_b;
                o_wr_allow = 1'b1;
            end
            OPC_NOT: begin
                o_result   = ~i_a;
                o_wr_allow = 1'b1;
            end
            OPC_LSH: begin
                o_result   = i_a << w_shamt;
                o_wr_allow = 1'b1;
            end
            OPC_ARSH: begin
                o_result   = w_arsh;
                o_wr_allow = 1'b1;
            end
            OPC_RSH: begin
                o_result   = i_a >> w_shamt;
                o_wr_allow = 1'b1;
            end
            default: begin
                o_result = '0;
            end
        endcase

        // Every defined non-NOP operation refreshes Z and N
        if (w_cls != OPC_NOP && w_cls != OPC_UNDEF) begin
            o_flag_mask[FLAG_Z] = 1'b1;
            o_flag_mask[FLAG_N] = 1'b1;
        end

        o_flag_next         = '0;
        o_flag_next[FLAG_C] = w_c;
        o_flag_next[FLAG_F] = w_f;
        o_flag_next[FLAG_L] = w_sub_diff[BIT_WIDTH];
        o_flag_next[FLAG_Z] = w_is_cmp ? (i_a == i_b) : (o_result == '0);
        o_flag_next[FLAG_N] = w_is_cmp ? ($signed(i_a) < $signed(i_b)) : o_result[MSB];
    end

endmodule

// File: rtl/datapath_exec_unit.sv
// Execution datapath: 2^SEL_WIDTH register file, operand muxes, ALU and registered Flags.
// Latency: Result combinational; register writes and Flags visible one edge later.
// Backpressure: none; a control word is executed every cycle. Optional debug read port under DATAPATH_DEBUG_PORT_EN.
module datapath_exec_unit
    import datapath_pkg::*;
#(
    parameter int BIT_WIDTH    = DP_BIT_WIDTH,
    parameter int OPCODE_WIDTH = DP_OPCODE_WIDTH,
    parameter int FLAG_WIDTH   = DP_FLAG_WIDTH,
    parameter int SEL_WIDTH    = DP_SEL_WIDTH
) (
    input  logic                    Clk,
    input  logic                    Rst,
`ifdef DATAPATH_DEBUG_PORT_EN
    input  logic [SEL_WIDTH-1:0]    Dbg_sel,
    output logic [BIT_WIDTH-1:0]    Dbg_data,
`endif
    input  logic [SEL_WIDTH-1:0]    Rsrc_mux_sel,
    input  logic [SEL_WIDTH-1:0]    Rdest_mux_sel,
    input  logic                    Imm_mux_sel,
    input  logic [BIT_WIDTH-1:0]    Imm_val,
    input  logic [OPCODE_WIDTH-1:0] Opcode,
    input  logic [BIT_WIDTH-1:0]    Reg_File_En,
    output logic [FLAG_WIDTH-1:0]   Flags,
    output logic [BIT_WIDTH-1:0]    Result
);

    localparam int REG_COUNT = 2 ** SEL_WIDTH;

    logic [BIT_WIDTH-1:0]  r_regs [REG_COUNT];
    logic [FLAG_WIDTH-1:0] r_flags;

    logic [BIT_WIDTH-1:0]  w_a;
    logic [BIT_WIDTH-1:0]  w_b;
    logic [BIT_WIDTH-1:0]  w_result;
    logic [FLAG_WIDTH-1:0] w_flag_next;
    logic [FLAG_WIDTH-1:0] w_flag_mask;
    logic                  w_wr_allow;

    // Operand A is always the destination; B is the immediate or the source register
    assign w_a = r_regs[Rdest_mux_sel];
    assign w_b = Imm_mux_sel ? Imm_val : r_regs[Rsrc_mux_sel];

    alu_core #(
        .BIT_WIDTH    (BIT_WIDTH),
        .OPCODE_WIDTH (OPCODE_WIDTH),
        .FLAG_WIDTH   (FLAG_WIDTH)
    ) u_alu (
        .i_a         (w_a),
        .i_b         (w_b),
        .i_opcode    (Opcode),
        .i_c_in      (r_flags[FLAG_C]),
        .o_result    (w_result),
        .o_flag_next (w_flag_next),
        .o_flag_mask (w_flag_mask),
        .o_wr_allow  (w_wr_allow)
    );

    // Register file: every enabled register takes the result, so several bits broadcast
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_allow) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (Reg_File_En[i] == 1'b1) begin
                    r_regs[i] <= w_result;
                end
            end
        end
    end

    // Flags: masked bits take the new value, the rest hold for the FSM's branch test
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_flags <= '0;
        end else begin
            r_flags <= (w_flag_next & w_flag_mask) | (r_flags & ~w_flag_mask);
        end
    end

    assign Flags  = r_flags;
    assign Result = w_result;

`ifdef DATAPATH_DEBUG_PORT_EN
    // Read-only peek into the register file; does not influence execution
    assign Dbg_data = r_regs[Dbg_sel];
`else
    // Debug read port not built.
`endif

endmodule

// File: tb/tb_datapath_exec_unit.sv
// Directed-vector bench for datapath_exec_unit: table of control words with expected Result/Flags.
// Each row: Result checked before the edge, Flags checked after it.
// Hand-written sequences cover reset at start and mid-run.
module tb_datapath_exec_unit;

    logic        Clk;
    logic        Rst;
    logic [3:0]  Rsrc_mux_sel;
    logic [3:0]  Rdest_mux_sel;
    logic        Imm_mux_sel;
    logic [15:0] Imm_val;
    logic [7:0]  Opcode;
    logic [15:0] Reg_File_En;
    logic [4:0]  Flags;
    logic [15:0] Result;

    int n_checks = 0;
    int n_errors = 0;

    datapath_exec_unit dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Rsrc_mux_sel  (Rsrc_mux_sel),
        .Rdest_mux_sel (Rdest_mux_sel),
        .Imm_mux_sel   (Imm_mux_sel),
        .Imm_val       (Imm_val),
        .Opcode        (Opcode),
        .Reg_File_En   (Reg_File_En),
        .Flags         (Flags),
        .Result        (Result)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  src;
        logic [3:0]  dst;
        logic        isel;
        logic [15:0] imm;
        logic [7:0]  opc;
        logic [15:0] en;
        logic [15:0] res;
        logic [4:0]  flg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] src, input logic [3:0] dst, input logic isel,
                                input logic [15:0] imm, input logic [7:0] opc, input logic [15:0] en,
                                input logic [15:0] res, input logic [4:0] flg);
        vec_t v;
        v.src = src; v.dst = dst; v.isel = isel; v.imm = imm;
        v.opc = opc; v.en = en; v.res = res; v.flg = flg;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] src, input logic [3:0] dst, input logic isel,
                         input logic [15:0] imm, input logic [7:0] opc, input logic [15:0] en);
        Rsrc_mux_sel  = src;
        Rdest_mux_sel = dst;
        Imm_mux_sel   = isel;
        Imm_val       = imm;
        Opcode        = opc;
        Reg_File_En   = en;
    endtask

    initial begin
        // Flags order {C,Z,F,L,N}. Opcodes: ORI=20 ANDI=10 ADDI=50 ADDUI=60 ADDCI=70 SUBI=90 CMPI=B0
        // ADDU=06 ADDC=07 SUB=09 CMP=0B XORI=30 NOT=04 LSHI=80 LSH=84 ARSHI=82 RSH=88 RSHI=8A
        // Load multiplicand/multiplier
        vecs.push_back(mk(0, 0, 1, 16'd6,    8'h60, 16'h0001, 16'd6,    5'b00000));
        vecs.push_back(mk(0, 1, 1, 16'd5,    8'h60, 16'h0002, 16'd5,    5'b00000));
        // Shift-add multiply 6*5: CMPI R1,0 / ANDI R1,1 / [ADDU R2,R0] / LSHI R0 / RSHI R1
        vecs.push_back(mk(0, 1, 1, 16'd0,    8'hB0, 16'h0000, 16'd5,    5'b00000));
        vecs.push_back(mk(0, 1, 1, 16'd1,    8'h10, 16'h0000, 16'd1,    5'b00000));
        vecs.push_back(mk(0, 2, 0, 16'd0,    8'h06, 16'h0004, 16'd6,    5'b00000));
        vecs.push_back(mk(0, 0, 1, 16'd1,    8'h80, 16'h0001, 16'd12,   5'b00000));
        vecs.push_back(mk(0, 1, 1, 16'd1,    8'h8A, 16'h0002, 16'd2,    5'b00000));
        vecs.push_back(mk(0, 1, 1, 16'd0,    8'hB0, 16'h0000, 16'd2,    5'b00000));
        vecs.push_back(mk(0, 1, 1, 16'd1,    8'h10, 16'h0000, 16'd0,    5'b01000));
        vecs.push_back(mk(0, 0, 1, 16'd1,    8'h80, 16'h0001, 16'd24,   5'b00000));
        vecs.push_back(mk(0, 1, 1, 16'd1,    8'h8A, 16'h0002, 16'd1,    5'b00000));
        vecs.push_back(mk(0, 1, 1, 16'd0,    8'hB0, 16'h0000, 16'd1,    5'b00000));
        vecs.push_back(mk(0, 1, 1, 16'd1,    8'h10, 16'h0000, 16'd1,    5'b00000));
        vecs.push_back(mk(0, 2, 0, 16'd0,    8'h06, 16'h0004, 16'd30,   5'b00000));
        vecs.push_back(mk(0, 0, 1, 16'd1,    8'h80, 16'h0001, 16'd48,   5'b00000));
        vecs.push_back(mk(0, 1, 1, 16'd1,    8'h8A, 16'h0002, 16'd0,    5'b01000));
        vecs.push_back(mk(0, 1, 1, 16'd0,    8'hB0, 16'h0000, 16'd0,    5'b01000));
        vecs.push_back(mk(0, 2, 1, 16'd0,    8'h20, 16'h0000, 16'd30,   5'b00000));
        // Signed overflow
        vecs.push_back(mk(0, 0, 1, 16'd0,    8'h10, 16'h0001, 16'd0,    5'b01000));
        vecs.push_back(mk(0, 0, 1, 16'h7FFF, 8'h60, 16'h0001, 16'h7FFF, 5'b00000));
        vecs.push_back(mk(0, 0, 1, 16'd1,    8'h50, 16'h0001, 16'h8000, 5'b00101));
        vecs.push_back(mk(0, 0, 1, 16'd0,    8'h20, 16'h0000, 16'h8000, 5'b00101));
        // Carry chain
        vecs.push_back(mk(0, 0, 1, 16'hFFFF, 8'h20, 16'h0001, 16'hFFFF, 5'b00101));
        vecs.push_back(mk(0, 0, 1, 16'd1,    8'h60, 16'h0001, 16'h0000, 5'b11100));
        vecs.push_back(mk(1, 1, 0, 16'd0,    8'h07, 16'h0002, 16'd1,    5'b00000));
        vecs.push_back(mk(0, 1, 1, 16'd0,    8'h20, 16'h0000, 16'd1,    5'b00000));
        // Compare, then NOP / undefined opcode with all enables set must hold everything
        vecs.push_back(mk(0, 3, 1, 16'd3,    8'h60, 16'h0008, 16'd3,    5'b00000));
        vecs.push_back(mk(0, 3, 1, 16'd5,    8'hB0, 16'h0008, 16'hFFFE, 5'b00011));
        vecs.push_back(mk(0, 3, 1, 16'd0,    8'h00, 16'hFFFF, 16'h0000, 5'b00011));
        vecs.push_back(mk(0, 3, 1, 16'd7,    8'h4F, 16'hFFFF, 16'h0000, 5'b00011));
        vecs.push_back(mk(0, 3, 1, 16'd0,    8'h20, 16'h0000, 16'd3,    5'b00010));
        vecs.push_back(mk(0, 2, 1, 16'd0,    8'h20, 16'h0000, 16'd30,   5'b00010));
        // Broadcast write and arithmetic shift
        vecs.push_back(mk(0, 4, 1, 16'h8001, 8'h60, 16'h0030, 16'h8001, 5'b00011));
        vecs.push_back(mk(0, 5, 1, 16'd0,    8'h20, 16'h0000, 16'h8001, 5'b00011));
        vecs.push_back(mk(0, 4, 1, 16'd1,    8'h82, 16'h0010, 16'hC000, 5'b00011));
        vecs.push_back(mk(0, 4, 1, 16'd0,    8'h20, 16'h0000, 16'hC000, 5'b00011));
        vecs.push_back(mk(0, 5, 1, 16'd0,    8'h20, 16'h0000, 16'h8001, 5'b00011));
        // Mixed ops: borrow, xor, not, logical shifts, equal compare, sub/add overflow
        vecs.push_back(mk(4, 5, 0, 16'd0,    8'h09, 16'h0020, 16'hC001, 5'b10011));
        vecs.push_back(mk(0, 5, 1, 16'hFFFF, 8'h30, 16'h0000, 16'h3FFE, 5'b10010));
        vecs.push_back(mk(0, 4, 1, 16'd0,    8'h04, 16'h0000, 16'h3FFF, 5'b10010));
        vecs.push_back(mk(0, 4, 1, 16'd4,    8'h88, 16'h0000, 16'h0C00, 5'b10010));
        vecs.push_back(mk(1, 5, 0, 16'd0,    8'h84, 16'h0000, 16'h8002, 5'b10011));
        vecs.push_back(mk(4, 4, 0, 16'd0,    8'h0B, 16'h0000, 16'h0000, 5'b11000));
        vecs.push_back(mk(0, 1, 1, 16'd2,    8'h90, 16'h0000, 16'hFFFF, 5'b10001));
        vecs.push_back(mk(0, 5, 1, 16'h8000, 8'h50, 16'h0000, 16'h4001, 5'b10100));
        vecs.push_back(mk(0, 1, 1, 16'hFFFF, 8'h70, 16'h0000, 16'h0001, 5'b10000));

        // Reset at start
        Rst = 1'b0;
        drive(0, 0, 1, 16'd0, 8'h20, 16'h0000);
        repeat (2) @(posedge Clk);
        #1;
        check("reset flags", {11'd0, Flags}, 16'h0000);
        check("reset result", Result, 16'h0000);
        @(negedge Clk);
        Rst = 1'b1;

        // Table: Result before the edge, Flags after it
        foreach (vecs[i]) begin
            @(negedge Clk);
            drive(vecs[i].src, vecs[i].dst, vecs[i].isel, vecs[i].imm, vecs[i].opc, vecs[i].en);
            #1;
            check($sformatf("vec%0d result", i), Result, vecs[i].res);
            @(posedge Clk);
            #1;
            check($sformatf("vec%0d flags", i), {11'd0, Flags}, {11'd0, vecs[i].flg});
        end

        // Mid-run asynchronous reset, away from any clock edge
        @(negedge Clk);
        drive(0, 2, 1, 16'd0, 8'h20, 16'h0000);
        #1;
        check("pre-reset R2", Result, 16'd30);
        #1;
        Rst = 1'b0;
        #1;
        check("async reset flags", {11'd0, Flags}, 16'h0000);
        check("async reset R2", Result, 16'h0000);
        // A write attempt while reset is held must not land
        drive(0, 0, 1, 16'd9, 8'h60, 16'hFFFF);
        @(posedge Clk);
        #1;
        check("held reset result", Result, 16'd9);
        check("held reset flags", {11'd0, Flags}, 16'h0000);
        @(negedge Clk);
        Rst = 1'b1;
        drive(0, 0, 1, 16'd6, 8'h60, 16'h0001);
        #1;
        check("post-reset ADDUI result", Result, 16'd6);
        @(posedge Clk);
        #1;
        check("post-reset ADDUI flags", {11'd0, Flags}, 16'h0000);
        @(negedge Clk);
        drive(0, 0, 1, 16'd0, 8'h20, 16'h0000);
        #1;
        check("post-reset R0", Result, 16'd6);
        drive(0, 5, 1, 16'd0, 8'h20, 16'h0000);
        #1;
        check("post-reset R5", Result, 16'h0000);
        @(posedge Clk);
        #1;
        check("post-reset read flags", {11'd0, Flags}, 16'h0008);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
